// File: rtl/rv32_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pipe_pkg                                                        |
// | Shared pipeline types: operand-select codes and shadow-stage entry.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_XM = 2'b10;
    localparam logic [1:0] SEL_MW = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } shadow_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_select                                                           |
// | Per-operand youngest-first match of a source register against X/M/W. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fwd_select
    import rv32_pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  shadow_t           x,
    input  shadow_t           m,
    input  shadow_t           w,
    output logic [1:0]        sel,
    output logic              hazard
);

    // An X-stage match stalls regardless of kind, and W is always forwardable.
    logic w_unused;
    assign w_unused = x.is_load ^ w.is_load;

    always_comb begin
        sel    = SEL_RF;
        hazard = 1'b0;
        if (rs != '0) begin
            if (x.valid && (x.rd == rs)) begin
                hazard = 1'b1;
            end else if (m.valid && (m.rd == rs)) begin
                if (m.is_load) begin
                    hazard = 1'b1;
                end else begin
                    sel = SEL_XM;
                end
            end else if (w.valid && (w.rd == rs)) begin
                sel = SEL_MW;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_forward_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_forward_ctrl                                                  |
// | Decode-stage branch comparator bypass selects and hazard stall.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module branch_forward_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = rv32_pipe_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_hold,
    input  logic              flush,
    input  logic              d_valid,
    input  logic              d_is_branch,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_reg_write,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_is_load,
    output logic [1:0]        b_operand1_sel,
    output logic [1:0]        b_operand2_sel,
    output logic              stall_d,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_t          x_q, m_q, w_q;
    shadow_t          x_d, m_d;
    logic [CNT_W-1:0] stall_count_q;
    logic             hazard1, hazard2;

    fwd_select u_op1 (
        .rs     (d_rs1),
        .x      (x_q),
        .m      (m_q),
        .w      (w_q),
        .sel    (b_operand1_sel),
        .hazard (hazard1)
    );

    fwd_select u_op2 (
        .rs     (d_rs2),
        .x      (x_q),
        .m      (m_q),
        .w      (w_q),
        .sel    (b_operand2_sel),
        .hazard (hazard2)
    );

    assign stall_d     = d_valid & d_is_branch & (hazard1 | hazard2);
    assign stall_count = stall_count_q;

    // x0 writes are dropped at capture so valid alone marks a real writer.
    always_comb begin
        x_d = '0;
        if (!(flush | stall_d | ~d_valid | ~d_reg_write) && (d_rd != '0)) begin
            x_d.valid   = 1'b1;
            x_d.rd      = d_rd;
            x_d.is_load = d_is_load;
        end
        m_d = flush ? '0 : x_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q           <= '0;
            m_q           <= '0;
            w_q           <= '0;
            stall_count_q <= '0;
        end else if (!pipe_hold) begin
            x_q <= x_d;
            m_q <= m_d;
            w_q <= m_q;
            if (stall_d && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_forward_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_forward_ctrl                                               |
// | Directed and random checks against a stage-list reference model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_branch_forward_ctrl;

    localparam int CNT_W  = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_hold, flush, d_valid, d_is_branch;
    logic [REG_AW-1:0] d_rs1, d_rs2, d_rd;
    logic              d_reg_write, d_is_load;
    logic [1:0]        b_operand1_sel, b_operand2_sel;
    logic              stall_d;
    logic [CNT_W-1:0]  stall_count;

    branch_forward_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_hold      (pipe_hold),
        .flush          (flush),
        .d_valid        (d_valid),
        .d_is_branch    (d_is_branch),
        .d_rs1          (d_rs1),
        .d_rs2          (d_rs2),
        .d_reg_write    (d_reg_write),
        .d_rd           (d_rd),
        .d_is_load      (d_is_load),
        .b_operand1_sel (b_operand1_sel),
        .b_operand2_sel (b_operand2_sel),
        .stall_d        (stall_d),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: index 0 = X, 1 = M, 2 = W; each slot a producer or empty.
    bit     ref_wr[3];
    int     ref_rd[3];
    bit     ref_ld[3];
    longint ref_cnt;
    longint cnt_max = (64'd1 << CNT_W) - 1;

    logic [1:0]       s_sel1, s_sel2;
    logic             s_stall;
    logic [CNT_W-1:0] s_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_clear();
        for (int i = 0; i < 3; i++) begin
            ref_wr[i] = 1'b0;
            ref_rd[i] = 0;
            ref_ld[i] = 1'b0;
        end
        ref_cnt = 0;
    endfunction

    // Find the youngest stage producing rs; X is never ready, M only if not a load.
    function automatic void ref_operand(input int rs, output int sel, output bit hz);
        bit found = 1'b0;
        sel = 0;
        hz  = 1'b0;
        if (rs != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && ref_wr[i] && ref_rd[i] == rs) begin
                    found = 1'b1;
                    if (i == 0)       hz = 1'b1;
                    else if (i == 1)  begin if (ref_ld[i]) hz = 1'b1; else sel = 2; end
                    else              sel = 3;
                end
            end
        end
    endfunction

    task automatic cycle(input bit hold, input bit fl, input bit dv, input bit br,
                         input int rs1, input int rs2, input bit rw, input int rd, input bit ld);
        int e1, e2;
        bit h1, h2, est;
        pipe_hold   = hold;
        flush       = fl;
        d_valid     = dv;
        d_is_branch = br;
        d_rs1       = REG_AW'(rs1);
        d_rs2       = REG_AW'(rs2);
        d_reg_write = rw;
        d_rd        = REG_AW'(rd);
        d_is_load   = ld;
        ref_operand(rs1, e1, h1);
        ref_operand(rs2, e2, h2);
        est = dv && br && (h1 || h2);
        @(negedge clk);
        s_sel1  = b_operand1_sel;
        s_sel2  = b_operand2_sel;
        s_stall = stall_d;
        s_cnt   = stall_count;
        chk("sel1", 64'(s_sel1), 64'(e1));
        chk("sel2", 64'(s_sel2), 64'(e2));
        chk("stall_d", 64'(s_stall), 64'(est));
        chk("stall_count", 64'(s_cnt), 64'(ref_cnt));
        @(posedge clk);
        if (rst) begin
            ref_clear();
        end else if (!hold) begin
            if (est && ref_cnt < cnt_max) ref_cnt++;
            ref_wr[2] = ref_wr[1]; ref_rd[2] = ref_rd[1]; ref_ld[2] = ref_ld[1];
            ref_wr[1] = fl ? 1'b0 : ref_wr[0];
            ref_rd[1] = ref_rd[0]; ref_ld[1] = ref_ld[0];
            ref_wr[0] = !(fl || est || !dv || !rw) && rd != 0;
            ref_rd[0] = rd; ref_ld[0] = ld;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        ref_clear();
        rst = 1'b1;
        cycle(0, 0, 1, 1, 5, 6, 1, 5, 0);
        chk("reset_sel1", 64'(s_sel1), 64'd0);
        chk("reset_cnt", 64'(s_cnt), 64'd0);
        cycle(0, 0, 1, 1, 5, 6, 1, 5, 0);
        rst = 1'b0;

        // addi x5 ; beq x5,x6
        cycle(0, 0, 1, 0, 0, 0, 1, 5, 0);
        cycle(0, 0, 1, 1, 5, 6, 0, 0, 0);
        chk("alu_use_stall", 64'(s_stall), 64'd1);
        cycle(0, 0, 1, 1, 5, 6, 0, 0, 0);
        chk("alu_use_sel1", 64'(s_sel1), 64'h2);
        chk("alu_use_sel2", 64'(s_sel2), 64'h0);
        chk("alu_use_stall_rel", 64'(s_stall), 64'd0);
        chk("alu_use_cnt", 64'(s_cnt), 64'd1);
        idle(3);

        // lw x7 ; bne x7,x7
        cycle(0, 0, 1, 0, 0, 0, 1, 7, 1);
        cycle(0, 0, 1, 1, 7, 7, 0, 0, 0);
        chk("load_use_stall1", 64'(s_stall), 64'd1);
        cycle(0, 0, 1, 1, 7, 7, 0, 0, 0);
        chk("load_use_stall2", 64'(s_stall), 64'd1);
        cycle(0, 0, 1, 1, 7, 7, 0, 0, 0);
        chk("load_use_sel1", 64'(s_sel1), 64'h3);
        chk("load_use_sel2", 64'(s_sel2), 64'h3);
        chk("load_use_cnt", 64'(s_cnt), 64'd3);
        idle(3);

        // x3 in W and M together: M wins
        cycle(0, 0, 1, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 1, 0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 3, 0, 0, 0, 0);
        chk("m_beats_w_sel1", 64'(s_sel1), 64'h2);
        chk("m_beats_w_stall", 64'(s_stall), 64'd0);

        // addi x0 ; beq x0,x0
        cycle(0, 0, 1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 0);
        chk("x0_stall", 64'(s_stall), 64'd0);
        chk("x0_cnt", 64'(s_cnt), 64'd3);
        idle(3);

        // flushed producer never hazards
        cycle(0, 0, 1, 0, 0, 0, 1, 5, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 5, 5, 0, 0, 0);
        chk("flush_stall", 64'(s_stall), 64'd0);
        chk("flush_sel1", 64'(s_sel1), 64'h0);
        idle(3);

        // pipe_hold freezes a stall
        cycle(0, 0, 1, 0, 0, 0, 1, 5, 0);
        cycle(1, 0, 1, 1, 5, 6, 0, 0, 0);
        cycle(1, 0, 1, 1, 5, 6, 0, 0, 0);
        chk("hold_stall", 64'(s_stall), 64'd1);
        chk("hold_cnt", 64'(s_cnt), 64'd3);
        cycle(0, 0, 1, 1, 5, 6, 0, 0, 0);
        cycle(0, 0, 1, 1, 5, 6, 0, 0, 0);
        chk("hold_after_sel1", 64'(s_sel1), 64'h2);
        chk("hold_after_cnt", 64'(s_cnt), 64'd4);
        idle(3);

        // async reset in the middle of a load-use stall
        cycle(0, 0, 1, 0, 0, 0, 1, 9, 1);
        cycle(0, 0, 1, 1, 9, 0, 0, 0, 0);
        #2;
        chk("pre_rst_stall", 64'(stall_d), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_stall", 64'(stall_d), 64'd0);
        chk("async_rst_sel1", 64'(b_operand1_sel), 64'h0);
        chk("async_rst_cnt", 64'(stall_count), 64'd0);
        ref_clear();
        rst = 1'b0;
        cycle(0, 0, 1, 1, 9, 0, 0, 0, 0);

        // random traffic over a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
